img_frame_sched: RTL

IMG_FRAME_SCHED -- requirements
Module: img_frame_sched

---
 rtl/img_proc_pkg.sv | 8 +
 rtl/img_occ_counter.sv | 19 +
 rtl/img_frame_sched.sv | 90 +++++++++
 3 files changed

// File: rtl/img_proc_pkg.sv
// img_proc_pkg: shared FSM state encoding and counter-width helpers for the frame scheduler
package img_proc_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
  localparam int STALL_W = 32;
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/img_occ_counter.sv
// img_occ_counter: up/down occupancy counter saturating at 0 and MAX; inc+dec together holds
module img_occ_counter #(
  parameter int MAX = 4,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);
  // occupancy register; simultaneous inc/dec cancels out
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc && !dec && cnt != W'(MAX)) cnt <= cnt + 1'b1;
    else if (dec && !inc && cnt != '0) cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/img_frame_sched.sv
// img_frame_sched: feeds one frame of pixels into a line-buffered 3x3 window core with flow control (optional stall counter: IMG_SCHED_STALL_CNT_EN)
module img_frame_sched
  import img_proc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int NUM_BUFS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] s_pixel,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] core_pixel,
  output logic                  core_pixel_valid,
  input  logic                  core_line_done,
  output logic                  busy,
  output logic                  frame_done,
  input  logic                  done_clr,
  output logic [STALL_W-1:0]    stall_cycles
);
  localparam int PW = cnt_w(IMG_WIDTH - 1);
  localparam int LW = cnt_w(IMG_HEIGHT);
  localparam int OW = cnt_w(NUM_BUFS);
  state_t state, nxt;
  logic [PW-1:0] pix_cnt;
  logic [LW-1:0] in_lines, out_lines;
  logic [OW-1:0] occ;
  logic go, xfer, line_end, last_line, cld;
  assign go = (state == IDLE) && start;
  // rst gates s_ready so no pixel can slip through in the aborting cycle
  assign s_ready = !rst && (state == STREAM) && (occ < OW'(NUM_BUFS));
  assign xfer = s_valid && s_ready;
  assign core_pixel = s_pixel;
  assign core_pixel_valid = xfer;
  assign line_end = xfer && (pix_cnt == PW'(IMG_WIDTH - 1));
  assign last_line = line_end && (in_lines == LW'(IMG_HEIGHT - 1));
  assign cld = core_line_done && (state == STREAM || state == DRAIN);
  assign busy = (state != IDLE);
  assign frame_done = (state == DONE);
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  // next-state logic; start and done_clr only matter in their own states
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? STREAM : IDLE;
      STREAM:  nxt = last_line ? DRAIN : STREAM;
      DRAIN:   nxt = (out_lines >= LW'(IMG_HEIGHT - 2)) ? DONE : DRAIN;
      DONE:    nxt = done_clr ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  // pixel/line position and consumed-line count, cleared at frame start
  always_ff @(posedge clk) begin
    if (rst || go) begin
      pix_cnt <= '0;
      in_lines <= '0;
      out_lines <= '0;
    end else begin
      if (xfer) pix_cnt <= line_end ? '0 : pix_cnt + 1'b1;
      if (line_end) in_lines <= in_lines + 1'b1;
      if (cld && out_lines != LW'(IMG_HEIGHT)) out_lines <= out_lines + 1'b1;
    end
  end
  img_occ_counter #(.MAX(NUM_BUFS), .W(OW)) u_occ (
    .clk(clk),
    .rst(rst),
    .clr(go),
    .inc(line_end),
    .dec(cld),
    .cnt(occ)
  );
`ifdef IMG_SCHED_STALL_CNT_EN
  logic [STALL_W-1:0] stall_q;
  // saturating count of cycles where upstream offers a pixel we cannot take
  always_ff @(posedge clk) begin
    if (rst || go) stall_q <= '0;
    else if (s_valid && !s_ready && state != IDLE && stall_q != '1) stall_q <= stall_q + 1'b1;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif
endmodule
